// File: rtl/fetch_pcgen_pkg.sv
// fetch_pcgen_pkg: shared types and defaults for the dual-slot fetch front end
package fetch_pcgen_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam int FQ_DEPTH_DEF = 4;
  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  mask;
    logic [1:0]  taken;
    logic [31:0] taddr0;
    logic [31:0] taddr1;
    logic [3:0]  tsat;
    logic [63:0] data;
    logic        pred_ok;
    logic        data_ok;
  } fetch_entry_type;
  function automatic logic [1:0] slot_mask(input logic b2);
    return b2 ? 2'b10 : 2'b11;
  endfunction
endpackage

// File: rtl/fetch_pcgen_if.sv
// fetch_pcgen_if: btac, imem and decode signals of the fetch front end
interface fetch_pcgen_if;
  logic [31:0] get_pc0, get_pc1;
  logic        pred0_taken, pred1_taken;
  logic [31:0] pred0_taddr, pred1_taddr;
  logic [1:0]  pred0_tsat, pred1_tsat;
  logic        pred_miss;
  logic [31:0] pred_maddr;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic        out_valid, out_ready;
  logic [31:0] out_pc;
  logic [1:0]  out_mask;
  logic [63:0] out_instr;
  logic [1:0]  out_taken;
  logic [31:0] out_taddr0, out_taddr1;
  logic [3:0]  out_tsat;
  modport master (
    output get_pc0, get_pc1, req_valid, req_addr, out_valid, out_pc, out_mask, out_instr,
           out_taken, out_taddr0, out_taddr1, out_tsat,
    input  pred0_taken, pred1_taken, pred0_taddr, pred1_taddr, pred0_tsat, pred1_tsat,
           pred_miss, pred_maddr, req_ready, resp_valid, resp_data, out_ready
  );
  modport slave (
    input  get_pc0, get_pc1, req_valid, req_addr, out_valid, out_pc, out_mask, out_instr,
           out_taken, out_taddr0, out_taddr1, out_tsat,
    output pred0_taken, pred1_taken, pred0_taddr, pred1_taddr, pred0_tsat, pred1_tsat,
           pred_miss, pred_maddr, req_ready, resp_valid, resp_data, out_ready
  );
endinterface

// File: rtl/fetch_pcgen_queue.sv
// fetch_pcgen_queue: circular fetch queue pairing issued bundles with late predictions and in-order data
module fetch_pcgen_queue
  import fetch_pcgen_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            alloc_i,
  input  logic [31:0]     alloc_pc_i,
  input  logic [1:0]      alloc_mask_i,
  output logic [AW-1:0]   alloc_idx_o,
  input  logic            patch_i,
  input  logic [AW-1:0]   patch_idx_i,
  input  logic [1:0]      patch_taken_i,
  input  logic [31:0]     patch_taddr0_i,
  input  logic [31:0]     patch_taddr1_i,
  input  logic [3:0]      patch_tsat_i,
  input  logic            fill_i,
  input  logic [63:0]     fill_data_i,
  input  logic            pop_i,
  input  logic            flush_i,
  output logic [AW:0]     count_o,
  output fetch_entry_type head_o
);
  fetch_entry_type ent_q [DEPTH];
  logic [AW-1:0] head_q, tail_q, fill_q;
  logic [AW:0] count_q;
  // head view and allocation slot
  always_comb begin
    alloc_idx_o = tail_q;
    count_o = count_q;
    head_o = ent_q[head_q];
  end
  // fill_q tracks the oldest entry still waiting for data; a flush realigns every pointer to tail
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      fill_q <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      head_q <= tail_q;
      fill_q <= tail_q;
      count_q <= '0;
    end else begin
      if (alloc_i) ent_q[tail_q] <= '{pc: alloc_pc_i, mask: alloc_mask_i, default: '0};
      if (patch_i) begin
        ent_q[patch_idx_i].taken <= patch_taken_i;
        ent_q[patch_idx_i].taddr0 <= patch_taddr0_i;
        ent_q[patch_idx_i].taddr1 <= patch_taddr1_i;
        ent_q[patch_idx_i].tsat <= patch_tsat_i;
        ent_q[patch_idx_i].pred_ok <= 1'b1;
        if (patch_taken_i[0]) ent_q[patch_idx_i].mask[1] <= 1'b0;
      end
      if (fill_i) begin
        ent_q[fill_q].data <= fill_data_i;
        ent_q[fill_q].data_ok <= 1'b1;
      end
      fill_q <= fill_q + AW'(fill_i);
      tail_q <= tail_q + AW'(alloc_i);
      head_q <= head_q + AW'(pop_i);
      count_q <= count_q + (AW+1)'(alloc_i) - (AW+1)'(pop_i);
    end
  end
endmodule

// File: rtl/fetch_pcgen.sv
// fetch_pcgen: next-PC generation, bundle issue and prediction/response pairing for dual-slot fetch
module fetch_pcgen
  import fetch_pcgen_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int FQ_DEPTH = FQ_DEPTH_DEF
) (
  input logic           clock,
  input logic           reset,
  fetch_pcgen_if.master bus
);
  localparam int AW = $clog2(FQ_DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(FQ_DEPTH);
  logic [28:0] fpc_q, fpc_d;
  logic [1:0] smask_q, smask_d, r_mask_q;
  logic r_issued_q;
  logic [AW-1:0] r_tail_q, tail;
  logic [AW:0] inflight_q, inflight_d, drop_q, drop_d, count;
  logic [29:0] tgt;
  logic t0, t1, patch, redirect, accept, fill, pop;
  fetch_entry_type head;
  // redirect resolution, issue gating and next-PC selection; a redirect always costs one issue slot
  always_comb begin
    patch = r_issued_q && !bus.pred_miss;
    t0 = patch && bus.pred0_taken && r_mask_q[0];
    t1 = patch && bus.pred1_taken && !t0;
    redirect = bus.pred_miss || t0 || t1;
    tgt = bus.pred_miss ? bus.pred_maddr[31:2] : t0 ? bus.pred0_taddr[31:2] : bus.pred1_taddr[31:2];
    bus.get_pc0 = {fpc_q, 3'b000};
    bus.get_pc1 = {fpc_q, 3'b100};
    bus.req_addr = {fpc_q, 3'b000};
    bus.req_valid = !reset && !redirect && count < DEPTH_W && inflight_q < DEPTH_W;
    accept = bus.req_valid && bus.req_ready;
    fpc_d = redirect ? tgt[29:1] : accept ? fpc_q + 29'd1 : fpc_q;
    smask_d = redirect ? slot_mask(tgt[0]) : accept ? 2'b11 : smask_q;
    inflight_d = inflight_q + (AW+1)'(accept) - (AW+1)'(bus.resp_valid);
    drop_d = bus.pred_miss ? inflight_q - (AW+1)'(bus.resp_valid) : drop_q - (AW+1)'(bus.resp_valid && drop_q != '0);
    fill = bus.resp_valid && drop_q == '0 && !bus.pred_miss;
    bus.out_valid = count != '0 && head.pred_ok && head.data_ok;
    pop = bus.out_valid && bus.out_ready;
    bus.out_pc = head.pc;
    bus.out_mask = head.mask;
    bus.out_instr = head.data;
    bus.out_taken = head.taken;
    bus.out_taddr0 = head.taddr0;
    bus.out_taddr1 = head.taddr1;
    bus.out_tsat = head.tsat;
  end
  // fetch PC state; r_* capture every cycle but only matter the cycle after an accept
  always_ff @(posedge clock) begin
    if (reset) begin
      fpc_q <= RESET_PC[31:3];
      smask_q <= 2'b11;
      r_issued_q <= 1'b0;
      r_tail_q <= '0;
      r_mask_q <= 2'b11;
      inflight_q <= '0;
      drop_q <= '0;
    end else begin
      fpc_q <= fpc_d;
      smask_q <= smask_d;
      r_issued_q <= accept;
      r_tail_q <= tail;
      r_mask_q <= smask_q;
      inflight_q <= inflight_d;
      drop_q <= drop_d;
    end
  end
  fetch_pcgen_queue #(.DEPTH(FQ_DEPTH)) u_queue (
    .clock(clock),
    .reset(reset),
    .alloc_i(accept),
    .alloc_pc_i(bus.req_addr),
    .alloc_mask_i(smask_q),
    .alloc_idx_o(tail),
    .patch_i(patch),
    .patch_idx_i(r_tail_q),
    .patch_taken_i({t1, t0}),
    .patch_taddr0_i(bus.pred0_taddr),
    .patch_taddr1_i(bus.pred1_taddr),
    .patch_tsat_i({bus.pred1_tsat, bus.pred0_tsat}),
    .fill_i(fill),
    .fill_data_i(bus.resp_data),
    .pop_i(pop),
    .flush_i(bus.pred_miss),
    .count_o(count),
    .head_o(head)
  );
endmodule

// File: tb/tb_fetch_pcgen.sv
// tb_fetch_pcgen: directed and randomized checks of fetch_pcgen against a queue-based reference model
module tb_fetch_pcgen;
  localparam int D = 4;
  localparam logic [31:0] RPC = 32'h8000_0000;
  typedef struct {
    logic [31:0] pc;
    logic [1:0]  mask;
    logic [1:0]  taken;
    logic [31:0] ta0;
    logic [31:0] ta1;
    logic [3:0]  tsat;
    bit          pok;
    bit          dok;
  } me_t;
  typedef struct {
    logic [31:0] a;
    int          due;
  } im_t;
  logic clock = 1'b0;
  logic rst = 1'b1;
  int vecs = 0, errs = 0, cyc = 0, lat = 1;
  me_t mq[$];
  im_t imq[$];
  logic [31:0] m_fpc;
  logic [1:0] m_smask, m_pmask;
  bit m_pend;
  int m_infl, m_drop;
  fetch_pcgen_if bus();
  fetch_pcgen dut (.clock(clock), .reset(rst), .bus(bus));
  always #5 clock = ~clock;
  function automatic logic [63:0] img(input logic [31:0] a);
    return {~a, a ^ 32'h1234_5678};
  endfunction
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  task automatic m_reset();
    m_fpc = RPC;
    m_smask = 2'b11;
    m_pmask = 2'b11;
    m_pend = 0;
    m_infl = 0;
    m_drop = 0;
    mq.delete();
    imq.delete();
  endtask
  task automatic idle();
    rst = 1'b0;
    bus.pred0_taken = 1'b0;
    bus.pred1_taken = 1'b0;
    bus.pred0_taddr = '0;
    bus.pred1_taddr = '0;
    bus.pred0_tsat = '0;
    bus.pred1_tsat = '0;
    bus.pred_miss = 1'b0;
    bus.pred_maddr = '0;
    bus.req_ready = 1'b1;
    bus.out_ready = 1'b1;
    lat = 1;
  endtask
  task automatic settle();
    bus.resp_valid = !rst && imq.size() > 0 && imq[0].due <= cyc;
    bus.resp_data = '0;
    if (bus.resp_valid) bus.resp_data = img(imq[0].a);
    #2;
  endtask
  task automatic tick();
    bit pend, t0, t1, redir, erv, eov, acc, pop;
    logic [31:0] tgt, a0;
    me_t e;
    pend = m_pend && !bus.pred_miss;
    t0 = pend && bus.pred0_taken && m_pmask[0];
    t1 = pend && bus.pred1_taken && !t0;
    redir = bus.pred_miss || t0 || t1;
    erv = !rst && !redir && mq.size() < D && m_infl < D;
    eov = mq.size() > 0 && mq[0].pok && mq[0].dok;
    a0 = {m_fpc[31:3], 3'b000};
    chk("req_valid", 64'(bus.req_valid), 64'(erv));
    if (rst) m_reset();
    else begin
      chk("get_pc0", 64'(bus.get_pc0), 64'(a0));
      chk("get_pc1", 64'(bus.get_pc1), 64'(a0 + 32'd4));
      chk("req_addr", 64'(bus.req_addr), 64'(a0));
      chk("out_valid", 64'(bus.out_valid), 64'(eov));
      if (eov) begin
        e = mq[0];
        chk("out_pc", 64'(bus.out_pc), 64'(e.pc));
        chk("out_mask", 64'(bus.out_mask), 64'(e.mask));
        chk("out_taken", 64'(bus.out_taken), 64'(e.taken));
        chk("out_taddr0", 64'(bus.out_taddr0), 64'(e.ta0));
        chk("out_taddr1", 64'(bus.out_taddr1), 64'(e.ta1));
        chk("out_tsat", 64'(bus.out_tsat), 64'(e.tsat));
        chk("out_instr", bus.out_instr, img(e.pc));
      end
      acc = erv && bus.req_ready;
      pop = eov && bus.out_ready;
      if (bus.resp_valid) void'(imq.pop_front());
      if (bus.req_valid && bus.req_ready) imq.push_back('{a: bus.req_addr, due: cyc + lat});
      if (bus.pred_miss) begin
        mq.delete();
        m_drop = m_infl - int'(bus.resp_valid);
      end else begin
        if (pend && mq.size() > 0) begin
          e = mq[mq.size() - 1];
          e.taken = {t1, t0};
          e.ta0 = bus.pred0_taddr;
          e.ta1 = bus.pred1_taddr;
          e.tsat = {bus.pred1_tsat, bus.pred0_tsat};
          e.pok = 1;
          if (t0) e.mask[1] = 1'b0;
          mq[mq.size() - 1] = e;
        end
        if (bus.resp_valid) begin
          if (m_drop > 0) m_drop--;
          else
            for (int i = 0; i < mq.size(); i++)
              if (!mq[i].dok) begin
                e = mq[i];
                e.dok = 1;
                mq[i] = e;
                break;
              end
        end
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back('{pc: a0, mask: m_smask, default: '0});
      end
      m_infl += int'(acc) - int'(bus.resp_valid);
      tgt = bus.pred_miss ? bus.pred_maddr : t0 ? bus.pred0_taddr : bus.pred1_taddr;
      m_pmask = m_smask;
      m_pend = acc;
      if (redir) begin
        m_fpc = tgt;
        m_smask = tgt[2] ? 2'b10 : 2'b11;
      end else if (acc) begin
        m_fpc = a0 + 32'd8;
        m_smask = 2'b11;
      end
    end
    cyc++;
    @(posedge clock);
    #1;
  endtask
  task automatic step();
    settle();
    tick();
  endtask
  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask
  initial begin
    int n, bad;
    bit found;
    idle();
    m_reset();
    // sequential fetch, no predictions
    do_reset();
    settle();
    chk("seq_rv0", 64'(bus.req_valid), 64'd1);
    chk("seq_addr0", 64'(bus.req_addr), 64'h8000_0000);
    tick();
    settle();
    chk("seq_addr1", 64'(bus.req_addr), 64'h8000_0008);
    tick();
    settle();
    chk("seq_addr2", 64'(bus.req_addr), 64'h8000_0010);
    chk("seq_ovalid", 64'(bus.out_valid), 64'd1);
    chk("seq_opc", 64'(bus.out_pc), 64'h8000_0000);
    chk("seq_omask", 64'(bus.out_mask), 64'd3);
    chk("seq_otaken", 64'(bus.out_taken), 64'd0);
    tick();
    repeat (5) step();
    // slot-0 taken into the upper half of a bundle
    do_reset();
    step();
    bus.pred0_taken = 1'b1;
    bus.pred0_taddr = 32'h8000_0104;
    settle();
    chk("tk_bubble", 64'(bus.req_valid), 64'd0);
    tick();
    bus.pred0_taken = 1'b0;
    settle();
    chk("tk_rv", 64'(bus.req_valid), 64'd1);
    chk("tk_addr", 64'(bus.req_addr), 64'h8000_0100);
    chk("tk_ovalid", 64'(bus.out_valid), 64'd1);
    chk("tk_omask0", 64'(bus.out_mask), 64'd1);
    chk("tk_otaken0", 64'(bus.out_taken), 64'd1);
    chk("tk_otaddr0", 64'(bus.out_taddr0), 64'h8000_0104);
    tick();
    step();
    settle();
    chk("tk_ovalid1", 64'(bus.out_valid), 64'd1);
    chk("tk_opc1", 64'(bus.out_pc), 64'h8000_0100);
    chk("tk_omask1", 64'(bus.out_mask), 64'd2);
    tick();
    repeat (4) step();
    // miss with three requests in flight on a 3-cycle imem
    do_reset();
    lat = 3;
    repeat (3) step();
    bus.pred_miss = 1'b1;
    bus.pred_maddr = 32'h8000_2000;
    settle();
    chk("miss_bubble", 64'(bus.req_valid), 64'd0);
    tick();
    bus.pred_miss = 1'b0;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      settle();
      if (i == 0) chk("miss_addr", 64'(bus.req_addr), 64'h8000_2000);
      if (bus.out_valid) begin
        found = 1;
        chk("miss_opc", 64'(bus.out_pc), 64'h8000_2000);
      end
      tick();
    end
    chk("miss_seen", 64'(found), 64'd1);
    // decode stalled for ten cycles
    do_reset();
    bus.out_ready = 1'b0;
    n = 0;
    repeat (10) begin
      settle();
      if (bus.req_valid && bus.req_ready) n++;
      tick();
    end
    chk("stall_accepts", 64'(n), 64'(D));
    settle();
    chk("stall_rv", 64'(bus.req_valid), 64'd0);
    chk("stall_opc", 64'(bus.out_pc), 64'h8000_0000);
    tick();
    bus.out_ready = 1'b1;
    repeat (12) step();
    // miss and slot-1 taken together
    do_reset();
    step();
    bus.pred1_taken = 1'b1;
    bus.pred1_taddr = 32'h8000_0400;
    bus.pred_miss = 1'b1;
    bus.pred_maddr = 32'h8000_3008;
    settle();
    chk("mt_bubble", 64'(bus.req_valid), 64'd0);
    tick();
    idle();
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      settle();
      if (i == 0) chk("mt_addr", 64'(bus.req_addr), 64'h8000_3008);
      if (bus.req_valid && bus.req_addr == 32'h8000_0400) bad++;
      tick();
    end
    chk("mt_no_taddr1", 64'(bad), 64'd0);
    // reset while two bundles wait in the queue
    do_reset();
    bus.out_ready = 1'b0;
    step();
    step();
    bus.req_ready = 1'b0;
    step();
    settle();
    chk("rq_ovalid", 64'(bus.out_valid), 64'd1);
    tick();
    rst = 1'b1;
    step();
    rst = 1'b0;
    settle();
    chk("rq_ovalid_after", 64'(bus.out_valid), 64'd0);
    chk("rq_addr_after", 64'(bus.req_addr), 64'h8000_0000);
    tick();
    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 499) == 0);
      bus.pred0_taken = ($urandom_range(0, 4) == 0);
      bus.pred1_taken = ($urandom_range(0, 4) == 0);
      bus.pred0_taddr = 32'h8000_0000 | ($urandom & 32'h0000_0fff);
      bus.pred1_taddr = 32'h8000_0000 | ($urandom & 32'h0000_0fff);
      bus.pred0_tsat = 2'($urandom);
      bus.pred1_tsat = 2'($urandom);
      bus.pred_miss = ($urandom_range(0, 24) == 0);
      bus.pred_maddr = 32'h8000_0000 | ($urandom & 32'h0000_0fff);
      bus.req_ready = ($urandom_range(0, 4) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      lat = $urandom_range(1, 4);
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
